// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Contents:
//   DATA_W_DEF / ADDR_W_DEF : default operand width and register-address width
//   CNT_W_DEF               : iteration counter width for the default operand width
//   op_e                    : operation encoding presented on op_i
//   state_e                 : control FSM states
package muldiv_pkg;

  localparam int DATA_W_DEF = 34;
  localparam int ADDR_W_DEF = 5;
  localparam int CNT_W_DEF  = $clog2(DATA_W_DEF) + 1;

  typedef enum logic [1:0] {
    OP_MUL  = 2'd0,
    OP_MULH = 2'd1,
    OP_DIV  = 2'd2,
    OP_REM  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_step_mod.sv
// One combinational iteration of the multiply/divide datapath.
// Ports:
//   is_div_i : 1 = restoring-divide step, 0 = shift-add multiply step
//   hi_i     : upper accumulator (multiply: product high word, divide: partial remainder)
//   lo_i     : lower accumulator (multiply: product low word / remaining multiplier bits,
//              divide: remaining dividend bits shifting out, quotient bits shifting in)
//   opnd_i   : multiplicand (multiply) or divisor (divide)
//   hi_o     : next upper accumulator
//   lo_o     : next lower accumulator
module muldiv_step_mod
  import muldiv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              is_div_i,
  input  logic [DATA_W:0]   hi_i,
  input  logic [DATA_W-1:0] lo_i,
  input  logic [DATA_W-1:0] opnd_i,
  output logic [DATA_W:0]   hi_o,
  output logic [DATA_W-1:0] lo_o
);

  logic [DATA_W:0]   addend;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   shifted;
  logic [DATA_W+1:0] diff;

  // Multiply consumes the multiplier LSB-first from lo_i[0]; the add result is one bit
  // wider than a word so the carry survives the right shift of the whole product.
  // Divide shifts the next dividend bit into the remainder and trial-subtracts the
  // divisor; the extra top bit of diff acts as the borrow that selects restore or keep.
  always_comb begin
    addend  = lo_i[0] ? {1'b0, opnd_i} : '0;
    sum     = hi_i + addend;
    shifted = {hi_i[DATA_W-1:0], lo_i[DATA_W-1]};
    diff    = {1'b0, shifted} - {2'b00, opnd_i};
    hi_o    = '0;
    lo_o    = '0;
    if (is_div_i) begin
      if (diff[DATA_W+1]) begin
        hi_o = shifted;
        lo_o = {lo_i[DATA_W-2:0], 1'b0};
      end else begin
        hi_o = diff[DATA_W:0];
        lo_o = {lo_i[DATA_W-2:0], 1'b1};
      end
    end else begin
      hi_o = {1'b0, sum[DATA_W:1]};
      lo_o = {sum[0], lo_i[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit_mod.sv
// Iterative unsigned multiply/divide unit feeding register-file write port 3.
// Ports:
//   clk, rst_n   : clock (rising edge) and asynchronous active-low reset
//   start_i      : request a new operation, accepted only when the unit is idle
//   op_i         : 0=MUL low word, 1=MULH high word, 2=DIV quotient, 3=REM remainder
//   operand_a_i  : multiplicand / dividend
//   operand_b_i  : multiplier / divisor
//   dest_addr_i  : destination register index
//   busy_o       : unit occupied, core must stall
//   result_o     : result word, held after the write strobe
//   wb_addr_o    : destination register index, held after the write strobe
//   wb_en_o      : one-cycle register-file write strobe
module muldiv_unit_mod
  import muldiv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] operand_a_i,
  input  logic [DATA_W-1:0] operand_b_i,
  input  logic [ADDR_W-1:0] dest_addr_i,
  output logic              busy_o,
  output logic [DATA_W-1:0] result_o,
  output logic [ADDR_W-1:0] wb_addr_o,
  output logic              wb_en_o
);

  localparam int CntW = $clog2(DATA_W) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(DATA_W - 1);

  state_e            state_q;
  op_e               op_q;
  logic [CntW-1:0]   cnt_q;
  logic [DATA_W:0]   hi_q;
  logic [DATA_W-1:0] lo_q;
  logic [DATA_W-1:0] opnd_q;
  logic              div0_q;
  logic [ADDR_W-1:0] dest_q;
  logic              busy_q;
  logic              wb_en_q;
  logic [DATA_W-1:0] result_q;
  logic [ADDR_W-1:0] wb_addr_q;

  logic [DATA_W:0]   hi_d;
  logic [DATA_W-1:0] lo_d;
  logic [DATA_W-1:0] result_d;
  logic              is_div;
  logic              start_div;
  logic              start_ok;

  assign is_div    = (op_q == OP_DIV) || (op_q == OP_REM);
  assign start_div = (op_e'(op_i) == OP_DIV) || (op_e'(op_i) == OP_REM);
  // busy_q is still set during the strobe cycle, so a request there is ignored.
  assign start_ok  = start_i && !busy_q;

  muldiv_step_mod #(.DATA_W(DATA_W)) u_step (
    .is_div_i (is_div),
    .hi_i     (hi_q),
    .lo_i     (lo_q),
    .opnd_i   (opnd_q),
    .hi_o     (hi_d),
    .lo_o     (lo_d)
  );

  // Result word selection once iteration is finished. A zero divisor skips CALC,
  // so lo_q still holds the original dividend, which is exactly the REM answer.
  always_comb begin
    result_d = lo_q;
    unique case (op_q)
      OP_MUL:  result_d = lo_q;
      OP_MULH: result_d = hi_q[DATA_W-1:0];
      OP_DIV:  result_d = div0_q ? '1 : lo_q;
      OP_REM:  result_d = div0_q ? lo_q : hi_q[DATA_W-1:0];
      default: result_d = lo_q;
    endcase
  end

  // Control FSM with registered outputs. The write strobe is registered while
  // leaving DONE, so it appears one edge after DONE is entered; busy stays high
  // through that strobe cycle and drops on the following edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= OP_MUL;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      div0_q    <= 1'b0;
      dest_q    <= '0;
      busy_q    <= 1'b0;
      wb_en_q   <= 1'b0;
      result_q  <= '0;
      wb_addr_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          wb_en_q <= 1'b0;
          busy_q  <= 1'b0;
          if (start_ok) begin
            op_q   <= op_e'(op_i);
            dest_q <= dest_addr_i;
            cnt_q  <= '0;
            hi_q   <= '0;
            busy_q <= 1'b1;
            if (start_div) begin
              lo_q   <= operand_a_i;
              opnd_q <= operand_b_i;
            end else begin
              lo_q   <= operand_b_i;
              opnd_q <= operand_a_i;
            end
            if (start_div && (operand_b_i == '0)) begin
              div0_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              div0_q  <= 1'b0;
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          wb_en_q   <= 1'b1;
          result_q  <= result_d;
          wb_addr_q <= dest_q;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign wb_en_o   = wb_en_q;
  assign result_o  = result_q;
  assign wb_addr_o = wb_addr_q;

endmodule

// File: tb/tb_muldiv_unit_mod.sv
// Self-checking bench for muldiv_unit_mod: directed corner cases followed by random
// operations, with expected writes queued at issue time and compared by a monitor.
module tb_muldiv_unit_mod;
  import muldiv_pkg::*;

  localparam int W   = 34;
  localparam int A   = 5;
  localparam int LAT = W + 1;

  logic         clk = 1'b0;
  logic         rstN = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'd0;
  logic [W-1:0] opA = '0;
  logic [W-1:0] opB = '0;
  logic [A-1:0] dest = '0;
  logic         busy;
  logic [W-1:0] result;
  logic [A-1:0] wbAddr;
  logic         wbEn;

  typedef struct {
    logic [W-1:0] result;
    logic [A-1:0] addr;
    int           edgeIdx;
  } expT;

  expT scoreboard[$];
  expT monExp;
  int  checks = 0;
  int  errors = 0;
  int  edgeCount = 0;

  muldiv_unit_mod #(.DATA_W(W), .ADDR_W(A)) dut (
    .clk         (clk),
    .rst_n       (rstN),
    .start_i     (start),
    .op_i        (op),
    .operand_a_i (opA),
    .operand_b_i (opB),
    .dest_addr_i (dest),
    .busy_o      (busy),
    .result_o    (result),
    .wb_addr_o   (wbAddr),
    .wb_en_o     (wbEn)
  );

  // Free-running clock, 10 ns period.
  always #5 clk = ~clk;

  // Rising-edge counter used to time-stamp issues and strobes.
  always @(posedge clk) edgeCount <= edgeCount + 1;

  // Architectural reference: plain unsigned arithmetic on the operation definitions.
  function automatic logic [W-1:0] refModel(input logic [1:0] o, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    case (o)
      2'd0:    return p[W-1:0];
      2'd1:    return p[2*W-1:W];
      2'd2:    return (b == '0) ? {W{1'b1}} : a / b;
      default: return (b == '0) ? a : a % b;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Bounded wait until the unit has fully returned to idle.
  task automatic waitIdle();
    int n;
    n = 0;
    while ((busy !== 1'b0 || wbEn !== 1'b0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("[TB] FAIL idleTimeout: busy=%0b wbEn=%0b, expected both 0", busy, wbEn);
    end
  endtask

  // Issue one operation and queue its expected write-back with its strobe edge.
  task automatic applyStimulus(input logic [1:0] o, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic [A-1:0] d);
    expT e;
    waitIdle();
    @(negedge clk);
    op    = o;
    opA   = a;
    opB   = b;
    dest  = d;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    opA   = {$urandom(), $urandom()};
    opB   = {$urandom(), $urandom()};
    dest  = A'($urandom());
    e.result  = refModel(o, a, b);
    e.addr    = d;
    e.edgeIdx = edgeCount + ((o >= 2'd2 && b == '0) ? 1 : LAT);
    scoreboard.push_back(e);
    checkOutput("busyAfterStart", 64'(busy), 64'd1);
  endtask

  // Monitor: every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rstN && wbEn === 1'b1) begin
      if (scoreboard.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedStrobe: got result %0h addr %0d, expected no write",
                 result, wbAddr);
      end else begin
        monExp = scoreboard.pop_front();
        checkOutput("result", 64'(result), 64'(monExp.result));
        checkOutput("wbAddr", 64'(wbAddr), 64'(monExp.addr));
        checkOutput("strobeEdge", 64'(edgeCount), 64'(monExp.edgeIdx));
        checkOutput("busyDuringStrobe", 64'(busy), 64'd1);
      end
    end
  end

  initial begin
    logic [63:0]  r1;
    logic [63:0]  r2;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int           n;

    // Reset state.
    rstN = 1'b0;
    #12;
    checkOutput("resetBusy", 64'(busy), 64'd0);
    checkOutput("resetWbEn", 64'(wbEn), 64'd0);
    checkOutput("resetResult", 64'(result), 64'd0);
    checkOutput("resetWbAddr", 64'(wbAddr), 64'd0);
    @(negedge clk);
    rstN = 1'b1;
    repeat (2) @(negedge clk);

    // Directed cases.
    applyStimulus(2'd0, 34'd7, 34'd6, 5'd5);
    applyStimulus(2'd1, 34'h2_0000_0000, 34'd4, 5'd1);
    applyStimulus(2'd0, 34'h2_0000_0000, 34'd4, 5'd2);
    applyStimulus(2'd2, 34'd100, 34'd7, 5'd3);
    applyStimulus(2'd3, 34'd100, 34'd7, 5'd4);
    applyStimulus(2'd2, 34'd123, 34'd0, 5'd6);
    applyStimulus(2'd3, 34'd123, 34'd0, 5'd0);
    applyStimulus(2'd1, {W{1'b1}}, {W{1'b1}}, 5'd31);
    applyStimulus(2'd2, {W{1'b1}}, 34'd1, 5'd30);

    // A second request while busy must be ignored entirely.
    applyStimulus(2'd0, 34'd3, 34'd3, 5'd7);
    repeat (10) @(negedge clk);
    op    = 2'd0;
    opA   = 34'd9;
    opB   = 34'd9;
    dest  = 5'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitIdle();

    // Asynchronous reset in the middle of a divide aborts it with no write.
    applyStimulus(2'd2, 34'd1000, 34'd3, 5'd12);
    repeat (20) @(posedge clk);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("abortBusy", 64'(busy), 64'd0);
    checkOutput("abortWbEn", 64'(wbEn), 64'd0);
    checkOutput("abortResult", 64'(result), 64'd0);
    scoreboard.delete();
    @(negedge clk);
    rstN = 1'b1;
    repeat (50) @(negedge clk);
    checkOutput("idleAfterAbort", 64'(busy), 64'd0);
    applyStimulus(2'd0, 34'd2, 34'd3, 5'd8);

    // Random operations, including zero and narrow divisors.
    for (int i = 0; i < 30; i++) begin
      r1 = {$urandom(), $urandom()};
      r2 = {$urandom(), $urandom()};
      ra = r1[W-1:0];
      rb = r2[W-1:0] >> $urandom_range(0, W);
      if ($urandom_range(0, 7) == 0) rb = '0;
      applyStimulus(2'($urandom_range(0, 3)), ra, rb, A'($urandom()));
    end

    // Drain the scoreboard with a bound.
    n = 0;
    while (scoreboard.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (scoreboard.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL missingStrobe: %0d writes outstanding, expected 0", scoreboard.size());
    end
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
